// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD bus controller: runs the power-up init sequence, then turns
// toggle-handshaked command/data words from the LCD output register into timed EN strobes.
module lcd_hd44780_ctrl #(
  parameter int unsigned T_PWRUP     = 750000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN        = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_init_done
);

  typedef enum logic [2:0] {
    ST_PWRUP, ST_LOAD, ST_SETUP, ST_PULSE, ST_HOLD, ST_EXEC, ST_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_EXEC_LONG - 1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             ack_tog;
  logic [1:0]       init_idx;
  logic [8:0]       req_q;
  logic             pending;
  logic             is_long;
  logic [CNT_W-1:0] exec_last;
  logic             unused_bits;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    return 8'h0C;  // display on, cursor off
      2'd2:    return 8'h01;  // clear
      default: return 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

  assign pending     = (i_io_lcd[30] != ack_tog);
  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign is_long     = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data[1:0] != 2'd0);
  assign exec_last   = is_long ? LONG_LAST : EXEC_LAST;
  assign o_lcd_rw    = 1'b0;
  assign unused_bits = ^i_io_lcd[29:9];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_lcd_on <= 1'b0;
    end else begin
      o_lcd_on <= i_io_lcd[31];
    end
  end

  // NOTE: all state and output registers use non-blocking assignments so every
  // branch below reads the pre-edge values, exactly as the flops will.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_PWRUP;
      timer       <= '0;
      ack_tog     <= 1'b0;
      init_idx    <= 2'd0;
      req_q       <= 9'd0;
      o_lcd_data  <= 8'd0;
      o_lcd_rs    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_busy      <= 1'b1;
      o_init_done <= 1'b0;
    end else begin
      case (state)
        ST_PWRUP: begin
          if (timer == PWRUP_LAST) begin
            timer <= '0;
            state <= ST_LOAD;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          if (!o_init_done) begin
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= init_cmd(init_idx);
          end else begin
            o_lcd_rs   <= req_q[8];
            o_lcd_data <= req_q[7:0];
          end
          timer <= '0;
          state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (timer == SETUP_LAST) begin
            timer    <= '0;
            o_lcd_en <= 1'b1;
            state    <= ST_PULSE;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (timer == EN_LAST) begin
            timer    <= '0;
            o_lcd_en <= 1'b0;
            state    <= ST_HOLD;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (timer == HOLD_LAST) begin
            timer <= '0;
            state <= ST_EXEC;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (timer == exec_last) begin
            timer <= '0;
            if (!o_init_done && (init_idx != 2'd3)) begin
              init_idx <= init_idx + 2'd1;
              state    <= ST_LOAD;
            end else begin
              o_init_done <= 1'b1;
              o_busy      <= 1'b0;
              state       <= ST_IDLE;
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          // Requests that toggled while busy are still pending here and get taken now.
          if (pending) begin
            req_q   <= i_io_lcd[8:0];
            ack_tog <= i_io_lcd[30];
            o_busy  <= 1'b1;
            timer   <= '0;
            state   <= ST_LOAD;
          end
        end
        default: begin
          timer <= '0;
          state <= ST_PWRUP;
        end
      endcase
    end
  end

endmodule
